// File: rtl/fs_ds_inst_queue_if.sv
// IF -> queue -> ID handshake bundle: IF entry handshake, ID head handshake, redirect flush and fill level.
// master drives IF/ID-side inputs; slave is the queue itself.
interface fs_ds_inst_queue_if #(
  parameter int unsigned BUS_WD = 64,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              fs_to_q_valid;
  logic [BUS_WD-1:0] fs_to_q_bus;
  logic              q_allowin;
  logic              q_to_ds_valid;
  logic [BUS_WD-1:0] q_to_ds_bus;
  logic              ds_allowin;
  logic [CNT_W-1:0]  q_count;
  logic              q_almost_full;

  modport master (
    output flush, fs_to_q_valid, fs_to_q_bus, ds_allowin,
    input  q_allowin, q_to_ds_valid, q_to_ds_bus, q_count, q_almost_full
  );

  modport slave (
    input  flush, fs_to_q_valid, fs_to_q_bus, ds_allowin,
    output q_allowin, q_to_ds_valid, q_to_ds_bus, q_count, q_almost_full
  );
endinterface

// File: rtl/fs_ds_inst_queue.sv
// DEPTH-entry instruction FIFO between IF and ID with valid/allowin handshake,
// optional empty-queue bypass and a redirect flush that discards every queued entry.
module fs_ds_inst_queue #(
  parameter int unsigned BUS_WD = 64,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned BYPASS = 1
) (
  input  logic                clk,
  input  logic                resetn,
  fs_ds_inst_queue_if.slave   q
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam bit          BYP   = (BYPASS != 0);

  logic [BUS_WD-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              empty;
  logic              bypass_hit;
  logic              push;
  logic              pop;
  logic              head_valid;
  logic [BUS_WD-1:0] head_bus;
  logic              allowin;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [PTR_W-1:0]  wr_ptr_nxt;

  // Head selection, handshake qualification and pointer wrap.
  always_comb begin
    empty      = 1'b0;
    bypass_hit = 1'b0;
    head_valid = 1'b0;
    head_bus   = '0;
    allowin    = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;

    empty      = (count == '0);
    bypass_hit = BYP & empty & q.fs_to_q_valid & q.ds_allowin;

    if (BYP && empty) begin
      head_valid = q.fs_to_q_valid;
      head_bus   = q.fs_to_q_bus;
    end else begin
      head_valid = ~empty;
      head_bus   = mem[rd_ptr];
    end
    // A redirect hides the head and swallows whatever IF offers.
    head_valid = head_valid & ~q.flush;

    allowin = q.flush | (count < CNT_W'(DEPTH)) | (q.ds_allowin & ~empty);
    push    = q.fs_to_q_valid & allowin & ~q.flush & ~bypass_hit;
    pop     = head_valid & q.ds_allowin & ~q.flush & ~empty;

    rd_ptr_nxt = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
    wr_ptr_nxt = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (q.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr_nxt;
      if (pop)  rd_ptr <= rd_ptr_nxt;
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Entry storage carries no reset; contents are qualified by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= q.fs_to_q_bus;
  end

  assign q.q_allowin     = allowin;
  assign q.q_to_ds_valid = head_valid;
  assign q.q_to_ds_bus   = head_bus;
  assign q.q_count       = count;
  assign q.q_almost_full = (count >= CNT_W'(DEPTH - 1));

endmodule

// File: tb/tb_fs_ds_inst_queue.sv
// Drives three queue variants (D4 bypass, D4 registered, D3 bypass) with one shared stimulus
// and compares each against its own behavioural FIFO model every cycle.
module tb_fs_ds_inst_queue;
  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        fs_valid;
  logic [63:0] fs_bus;
  logic        ds_allowin;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fs_ds_inst_queue_if #(.BUS_WD(64), .DEPTH(4)) if0 ();
  fs_ds_inst_queue_if #(.BUS_WD(64), .DEPTH(4)) if1 ();
  fs_ds_inst_queue_if #(.BUS_WD(64), .DEPTH(3)) if2 ();

  fs_ds_inst_queue #(.BUS_WD(64), .DEPTH(4), .BYPASS(1)) dut0 (.clk(clk), .resetn(resetn), .q(if0.slave));
  fs_ds_inst_queue #(.BUS_WD(64), .DEPTH(4), .BYPASS(0)) dut1 (.clk(clk), .resetn(resetn), .q(if1.slave));
  fs_ds_inst_queue #(.BUS_WD(64), .DEPTH(3), .BYPASS(1)) dut2 (.clk(clk), .resetn(resetn), .q(if2.slave));

  assign if0.flush = flush; assign if0.fs_to_q_valid = fs_valid; assign if0.fs_to_q_bus = fs_bus; assign if0.ds_allowin = ds_allowin;
  assign if1.flush = flush; assign if1.fs_to_q_valid = fs_valid; assign if1.fs_to_q_bus = fs_bus; assign if1.ds_allowin = ds_allowin;
  assign if2.flush = flush; assign if2.fs_to_q_valid = fs_valid; assign if2.fs_to_q_bus = fs_bus; assign if2.ds_allowin = ds_allowin;

  logic        o_valid [3];
  logic [63:0] o_bus   [3];
  logic        o_allow [3];
  logic [31:0] o_cnt   [3];
  logic        o_af    [3];

  assign o_valid[0] = if0.q_to_ds_valid; assign o_bus[0] = if0.q_to_ds_bus; assign o_allow[0] = if0.q_allowin;
  assign o_valid[1] = if1.q_to_ds_valid; assign o_bus[1] = if1.q_to_ds_bus; assign o_allow[1] = if1.q_allowin;
  assign o_valid[2] = if2.q_to_ds_valid; assign o_bus[2] = if2.q_to_ds_bus; assign o_allow[2] = if2.q_allowin;
  assign o_cnt[0] = 32'(if0.q_count); assign o_af[0] = if0.q_almost_full;
  assign o_cnt[1] = 32'(if1.q_count); assign o_af[1] = if1.q_almost_full;
  assign o_cnt[2] = 32'(if2.q_count); assign o_af[2] = if2.q_almost_full;

  // Reference model: one queue of stored entries per variant.
  int unsigned dep [3] = '{4, 4, 3};
  bit          byp [3] = '{1'b1, 1'b0, 1'b1};
  logic [63:0] mq [3][$];
  bit          m_push [3];
  bit          m_pop  [3];
  bit          m_take [3];
  bit          m_flush;
  logic [63:0] m_bus;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present inputs mid-cycle, then compare every variant against the model.
  task automatic apply(input logic v, input logic [63:0] b, input logic ds, input logic fl);
    fs_valid = v; fs_bus = b; ds_allowin = ds; flush = fl;
    #1;
    m_flush = fl; m_bus = b;
    for (int i = 0; i < 3; i++) begin
      int unsigned sz;
      bit mt, bmode, ev, ea, bh;
      logic [63:0] eb;
      sz    = mq[i].size();
      mt    = (sz == 0);
      bmode = byp[i] && mt;
      ev    = fl ? 1'b0 : (bmode ? v : !mt);
      eb    = bmode ? b : (mt ? 64'd0 : mq[i][0]);
      ea    = fl || (sz < dep[i]) || (ds && !mt);
      bh    = bmode && v && ds;
      m_pop[i]  = ev && ds && !fl && !mt;
      m_push[i] = v && ea && !fl && !bh;
      m_take[i] = m_push[i] || (bh && !fl);
      chk($sformatf("valid%0d", i), 64'(o_valid[i]), 64'(ev));
      if (ev) chk($sformatf("bus%0d", i), o_bus[i], eb);
      chk($sformatf("allowin%0d", i), 64'(o_allow[i]), 64'(ea));
      chk($sformatf("count%0d", i), 64'(o_cnt[i]), 64'(sz));
      chk($sformatf("afull%0d", i), 64'(o_af[i]), 64'(sz >= dep[i] - 1));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (m_flush) mq[i].delete();
      else begin
        if (m_pop[i])  void'(mq[i].pop_front());
        if (m_push[i]) mq[i].push_back(m_bus);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    fs_valid = 1'b0; fs_bus = '0; ds_allowin = 1'b0; flush = 1'b0;
    resetn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      chk($sformatf("rst_count%0d", i), 64'(o_cnt[i]), 64'd0);
      chk($sformatf("rst_valid%0d", i), 64'(o_valid[i]), 64'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  logic [31:0] pc;

  initial begin
    fs_valid = 1'b0; fs_bus = '0; ds_allowin = 1'b0; flush = 1'b0; resetn = 1'b0;
    @(negedge clk);
    do_reset();
    apply(1'b0, 64'd0, 1'b0, 1'b0);
    chk("reset_allowin", 64'(o_allow[0]), 64'd1);
    tick();

    // Fill with ID stalled; IF holds the fifth pc until accepted.
    pc = 32'hbfc00000;
    repeat (6) begin
      apply(1'b1, {32'd0, pc}, 1'b0, 1'b0);
      if (m_take[0]) pc = pc + 32'd4;
      tick();
    end
    apply(1'b1, {32'd0, pc}, 1'b0, 1'b0);
    chk("fill_count", 64'(o_cnt[0]), 64'd4);
    chk("fill_allowin", 64'(o_allow[0]), 64'd0);
    chk("fill_pc_held", 64'(pc), 64'h bfc00010);
    tick();

    // Continuous push/pop through the pointer wrap.
    repeat (10) begin
      apply(1'b1, {32'd0, pc}, 1'b1, 1'b0);
      if (m_take[0]) pc = pc + 32'd4;
      tick();
    end
    apply(1'b0, 64'd0, 1'b0, 1'b0);
    chk("drain_count", 64'(o_cnt[0]), 64'd4);
    tick();

    repeat (6) begin apply(1'b0, 64'd0, 1'b1, 1'b0); tick(); end

    // Empty-queue bypass vs registered path.
    apply(1'b1, 64'h00000000_bfc00000, 1'b1, 1'b0);
    chk("bypass_valid", 64'(o_valid[0]), 64'd1);
    chk("nobypass_valid", 64'(o_valid[1]), 64'd0);
    tick();
    apply(1'b0, 64'd0, 1'b1, 1'b0);
    chk("nobypass_late", o_bus[1], 64'h00000000_bfc00000);
    chk("bypass_count", 64'(o_cnt[0]), 64'd0);
    tick();

    // Flush with three queued entries and a concurrent push.
    for (int k = 0; k < 3; k++) begin apply(1'b1, 64'(32'hbfc00100 + 32'(k * 4)), 1'b0, 1'b0); tick(); end
    apply(1'b1, 64'h00000000_bfc0dead, 1'b1, 1'b1);
    chk("flush_valid", 64'(o_valid[0]), 64'd0);
    chk("flush_allowin", 64'(o_allow[0]), 64'd1);
    tick();
    apply(1'b0, 64'd0, 1'b1, 1'b0);
    chk("flush_count", 64'(o_cnt[0]), 64'd0);
    tick();

    // Randomized traffic, with a reset injected halfway.
    for (int n = 0; n < 200; n++) begin
      if (n == 100) begin
        apply(1'b1, {$urandom, $urandom}, 1'b0, 1'b0); tick();
        apply(1'b1, {$urandom, $urandom}, 1'b0, 1'b0); tick();
        do_reset();
      end
      apply(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 19) == 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
